atmr_vote_stage: RTL and testbench
==================================

# atmr_vote_stage

Registered approximate-TMR voter placed directly downstream of the three synthesized ALU replicas (8-bit result buses each). Every accepted beat it majority-votes the three replica words bitwise and tracks per-replica disagreement on the bits that matter. A replica that disagrees persistently is excluded, degrading TRIPLEX → DUPLEX → FAILED. The voted word leaves through a valid/ready register stage with mismatch and error status.

## Interface
Parameters:
- WIDTH, 8, replica / voted word width
- CARE_MASK, 8'hFF, bits that count for mismatch detection; voting uses all bits
- PERSIST, 3, consecutive mismatching beats (≥1) before a replica is declared faulty
- CNT_W, 16, width of saturating error counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  replica words valid
- in_ready  out  1  stage can accept; = !out_valid || out_ready
- rep_a / rep_b / rep_c  in  WIDTH each  replica 0/1/2 results
- clear  in  1  synchronous: return to TRIPLEX, zero streaks, faults and err_cnt
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- voted  out  WIDTH  voted / selected word
- mism  out  3  per-replica mismatch for this word (bit0 = A)
- uncorr  out  1  DUPLEX disagreement on this word
- fault  out  3  sticky excluded-replica flags
- mode  out  2  00 TRIPLEX, 01 DUPLEX, 10 FAILED
- err_cnt  out  CNT_W  saturating count of erroneous beats

## Operation
- Accept = in_valid && in_ready. Out-hold = out_valid && !out_ready: voted/mism/uncorr held stable.
- TRIPLEX: voted = (a&b)|(a&c)|(b&c). mism[i] = |((rep_i ^ voted) & CARE_MASK). uncorr = 0.
- DUPLEX: voted = lower-indexed healthy replica. uncorr = |((h0 ^ h1) & CARE_MASK). mism = 0. Streaks frozen.
- FAILED: voted = the single healthy replica. mism = 0, uncorr = 0, no checking.
- Streaks (TRIPLEX only, per accepted beat): streak_i+1 if mism[i], else 0. When streak_i reaches PERSIST, set fault[i] and zero streak_i.
- Several replicas may reach PERSIST on the same beat; all are faulted. If this would fault all three, fault[0] stays clear and A survives.
- mode = number of set fault bits: 0 → TRIPLEX, 1 → DUPLEX, 2 → FAILED. Derived combinationally from registered fault.
- err_cnt +1 per accepted beat with any mism bit or uncorr. Saturates at 2^CNT_W−1 (no wrap).
- clear: zeros fault, streaks, err_cnt next edge. Takes priority over status updates from a beat accepted in the same cycle. That beat's data path still uses the pre-clear mode.
- clear does not touch out_valid/voted.

## Timing
- Latency 1: beat accepted at edge N → voted/mism/uncorr valid, out_valid=1 after edge N.
- Full throughput: with out_ready held 1, one beat per cycle.
- Status (fault, mode, streaks, err_cnt) updates at the accepting edge. A mode change applies to the next accepted beat, never retroactively.
- out_valid clears on the edge where out_ready=1 and no new accept occurs.
- in_ready is combinational from out_valid/out_ready; no combinational path from in_valid to out_*.
- Reset (async assert, sync release): out_valid=0, voted=0, mism=0, uncorr=0, fault=0, mode=TRIPLEX, err_cnt=0, streaks=0. in_ready=1 after reset.
- Reset mid-stream drops the in-flight output word.

## Test plan
- TRIPLEX vote: a=8'h3C, b=8'h3C, c=8'hFF, out_ready=1 → next cycle voted=8'h3C, mism=3'b100, err_cnt=1.
- Persistence (PERSIST=3): c wrong for 2 beats, then correct, then wrong 3 beats → fault=3'b100 only after the 6th beat; mode=01 from the 7th beat; err_cnt=5.
- DUPLEX: fault=3'b100, a=8'h10, b=8'h11, CARE_MASK=8'hFE → uncorr=0, voted=8'h10. Then b=8'h12 → uncorr=1, voted=8'h10.
- Triple mismatch: a=3'b011, b=3'b101, c=3'b110 (upper bits 0) for 3 beats → voted=8'h07 each beat, mism=3'b111. Then fault=3'b110, mode=10, later voted=rep_a.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 → in_ready=0, voted stable, no status change. Release → one beat per cycle, no loss or duplication.
- Saturation/clear/reset: CNT_W=2, 5 erroneous beats → err_cnt=3. clear same cycle as erroneous accept → err_cnt=0, fault=0, that beat still output. Async rst_n low mid-transfer → out_valid=0 immediately.

Source files
------------

// File: rtl/atmr_vote_stage_if.sv
// Bundle for the ATMR voter: three replica words in, voted word plus status out.
// Latency: n/a (wiring only); the voter registers the output side.
// Backpressure: in_ready/out_ready follow plain valid/ready semantics.
//
// Ports (slave = voter side):
//   in_valid/in_ready      upstream handshake for the replica words
//   rep_a/rep_b/rep_c      replica 0/1/2 results, WIDTH bits each
//   clear                  synchronous status clear
//   out_valid/out_ready    downstream handshake for the voted word
//   voted/mism/uncorr      voted word, per-replica mismatch, duplex disagreement
//   fault/mode/err_cnt     sticky exclusions, redundancy level, error counter
interface atmr_vote_stage_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rep_a;
  logic [WIDTH-1:0] rep_b;
  logic [WIDTH-1:0] rep_c;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] voted;
  logic [2:0]       mism;
  logic             uncorr;
  logic [2:0]       fault;
  logic [1:0]       mode;
  logic [CNT_W-1:0] err_cnt;

  // Producer/consumer side (e.g. the replica cluster plus downstream sink).
  modport master (
    output in_valid, rep_a, rep_b, rep_c, clear, out_ready,
    input  in_ready, out_valid, voted, mism, uncorr, fault, mode, err_cnt
  );

  // Voter side.
  modport slave (
    input  in_valid, rep_a, rep_b, rep_c, clear, out_ready,
    output in_ready, out_valid, voted, mism, uncorr, fault, mode, err_cnt
  );

endinterface

// File: rtl/atmr_vote_stage.sv
// Approximate-TMR voter: bitwise majority of three replicas with persistent-fault exclusion.
// Latency: 1 cycle from accept to out_valid; full throughput when out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a held output word stays frozen.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (release expected synchronous to clk)
//   bus    atmr_vote_stage_if.slave: replica inputs, clear, voted output and status
module atmr_vote_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CARE_MASK = {WIDTH{1'b1}},
  parameter int               PERSIST   = 3,
  parameter int               CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  atmr_vote_stage_if.slave    bus
);

  // Streak counters only ever need to hold 0..PERSIST-1; reaching PERSIST
  // faults the replica and zeroes the counter in the same update.
  localparam int             SW   = $clog2(PERSIST + 1);
  localparam logic [SW-1:0]  LAST = SW'(PERSIST - 1);

  typedef enum logic [1:0] {
    M_TRIPLEX = 2'b00,
    M_DUPLEX  = 2'b01,
    M_FAILED  = 2'b10
  } mode_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     voted_q;
  logic [2:0]           mism_q;
  logic                 uncorr_q;
  logic [2:0]           fault_q, fault_d;
  logic [2:0][SW-1:0]   streak_q, streak_d;
  logic [CNT_W-1:0]     err_q, err_d;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic in_ready;
  logic accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Redundancy level, derived from the registered fault flags only, so a
  // fault raised on this beat affects the next accepted beat, not this one.
  // ---------------------------------------------------------------------
  logic [1:0] nfault;
  mode_e      mode;

  assign nfault = {1'b0, fault_q[0]} + {1'b0, fault_q[1]} + {1'b0, fault_q[2]};
  assign mode   = (nfault == 2'd0) ? M_TRIPLEX :
                  (nfault == 2'd1) ? M_DUPLEX  : M_FAILED;

  // ---------------------------------------------------------------------
  // Replica selection
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] h0, h1;   // two survivors in DUPLEX, lower index first
  logic [WIDTH-1:0] solo;     // sole survivor in FAILED

  assign maj = (bus.rep_a & bus.rep_b) | (bus.rep_a & bus.rep_c) | (bus.rep_b & bus.rep_c);

  always_comb begin
    h0 = bus.rep_a;
    h1 = bus.rep_b;
    if (fault_q[0]) begin
      h0 = bus.rep_b;
      h1 = bus.rep_c;
    end else if (fault_q[1]) begin
      h1 = bus.rep_c;
    end
  end

  assign solo = !fault_q[0] ? bus.rep_a :
                !fault_q[1] ? bus.rep_b : bus.rep_c;

  // ---------------------------------------------------------------------
  // Data path for the beat on the inputs this cycle
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] voted_d;
  logic [2:0]       mism_d;
  logic             uncorr_d;
  logic             beat_err;

  always_comb begin
    voted_d  = maj;
    mism_d   = '0;
    uncorr_d = 1'b0;
    unique case (mode)
      M_TRIPLEX: begin
        voted_d   = maj;
        // Voting uses every bit; only CARE_MASK bits count as disagreement.
        mism_d[0] = |((bus.rep_a ^ maj) & CARE_MASK);
        mism_d[1] = |((bus.rep_b ^ maj) & CARE_MASK);
        mism_d[2] = |((bus.rep_c ^ maj) & CARE_MASK);
      end
      M_DUPLEX: begin
        // Two survivors can detect but not correct: pass the lower index on.
        voted_d  = h0;
        uncorr_d = |((h0 ^ h1) & CARE_MASK);
      end
      default: begin
        voted_d = solo;
      end
    endcase
  end

  assign beat_err = (|mism_d) || uncorr_d;

  // ---------------------------------------------------------------------
  // Persistence tracking
  // ---------------------------------------------------------------------
  logic [2:0] hit;    // replica reaches PERSIST consecutive mismatches now
  logic [2:0] keep;   // faults actually applied

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit[i] = (mode == M_TRIPLEX) && mism_d[i] && (streak_q[i] == LAST);
    end
  end

  // Never exclude every replica: if all three trip together, A is kept so
  // the stage still has something to forward.
  assign keep = (&hit) ? {hit[2:1], 1'b0} : hit;

  always_comb begin
    fault_d  = fault_q;
    streak_d = streak_q;
    err_d    = err_q;
    if (bus.clear) begin
      // Wins over any status update from a beat accepted this cycle.
      fault_d  = '0;
      streak_d = '0;
      err_d    = '0;
    end else if (accept) begin
      // Streaks only move in TRIPLEX; in DUPLEX/FAILED they stay frozen.
      if (mode == M_TRIPLEX) begin
        fault_d = fault_q | keep;
        for (int i = 0; i < 3; i++) begin
          streak_d[i] = (mism_d[i] && !hit[i]) ? streak_q[i] + 1'b1 : '0;
        end
      end
      if (beat_err && !(&err_q)) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      voted_q     <= '0;
      mism_q      <= '0;
      uncorr_q    <= 1'b0;
      fault_q     <= '0;
      streak_q    <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      fault_q     <= fault_d;
      streak_q    <= streak_d;
      err_q       <= err_d;
      // Only a new accept replaces the word; a held word stays untouched.
      if (accept) begin
        voted_q  <= voted_d;
        mism_q   <= mism_d;
        uncorr_q <= uncorr_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.voted     = voted_q;
  assign bus.mism      = mism_q;
  assign bus.uncorr    = uncorr_q;
  assign bus.fault     = fault_q;
  assign bus.mode      = mode;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_atmr_vote_stage.sv
// Bench for atmr_vote_stage: two instances (default, and CARE_MASK=FE with CNT_W=2).
// Latency: expected words queued at accept, compared when the output handshakes.
// Backpressure: one stall sequence plus an async reset while a word is held.
module tb_atmr_vote_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       in_valid [2];
  logic       clear    [2];
  logic       out_ready[2];
  logic [7:0] rep_a    [2];
  logic [7:0] rep_b    [2];
  logic [7:0] rep_c    [2];

  logic        in_ready[2];
  logic        o_valid [2];
  logic        o_unc   [2];
  logic [7:0]  o_voted [2];
  logic [2:0]  o_mism  [2];
  logic [2:0]  o_fault [2];
  logic [1:0]  o_mode  [2];
  logic [15:0] o_err   [2];

  int tests = 0;
  int fails = 0;

  atmr_vote_stage_if #(.WIDTH(8), .CNT_W(16)) if0 ();
  atmr_vote_stage_if #(.WIDTH(8), .CNT_W(2))  if1 ();

  atmr_vote_stage #(.WIDTH(8), .CARE_MASK(8'hFF), .PERSIST(3), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  atmr_vote_stage #(.WIDTH(8), .CARE_MASK(8'hFE), .PERSIST(3), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  assign if0.in_valid  = in_valid[0];
  assign if0.clear     = clear[0];
  assign if0.out_ready = out_ready[0];
  assign if0.rep_a     = rep_a[0];
  assign if0.rep_b     = rep_b[0];
  assign if0.rep_c     = rep_c[0];
  assign in_ready[0]   = if0.in_ready;
  assign o_valid[0]    = if0.out_valid;
  assign o_unc[0]      = if0.uncorr;
  assign o_voted[0]    = if0.voted;
  assign o_mism[0]     = if0.mism;
  assign o_fault[0]    = if0.fault;
  assign o_mode[0]     = if0.mode;
  assign o_err[0]      = if0.err_cnt;

  assign if1.in_valid  = in_valid[1];
  assign if1.clear     = clear[1];
  assign if1.out_ready = out_ready[1];
  assign if1.rep_a     = rep_a[1];
  assign if1.rep_b     = rep_b[1];
  assign if1.rep_c     = rep_c[1];
  assign in_ready[1]   = if1.in_ready;
  assign o_valid[1]    = if1.out_valid;
  assign o_unc[1]      = if1.uncorr;
  assign o_voted[1]    = if1.voted;
  assign o_mism[1]     = if1.mism;
  assign o_fault[1]    = if1.fault;
  assign o_mode[1]     = if1.mode;
  assign o_err[1]      = {14'd0, if1.err_cnt};

  typedef struct {
    int          id;
    int          d;      // which instance
    logic [7:0]  a, b, c;
    logic        clr;
    logic [7:0]  voted;
    logic [2:0]  mism;
    logic        unc;
    logic [2:0]  fault;  // status right after the accepting edge
    logic [1:0]  mode;
    logic [15:0] err;
  } vec_t;

  vec_t tbl[$];
  vec_t q0[$];
  vec_t q1[$];

  function automatic vec_t mk(int d, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic clr,
                              logic [7:0] voted, logic [2:0] mism, logic unc,
                              logic [2:0] fault, logic [1:0] mode, logic [15:0] err);
    vec_t v;
    v.id = 0; v.d = d; v.a = a; v.b = b; v.c = c; v.clr = clr;
    v.voted = voted; v.mism = mism; v.unc = unc;
    v.fault = fault; v.mode = mode; v.err = err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.out_valid%0d", tag, d), o_valid[d], 0);
      chk($sformatf("%s.voted%0d", tag, d), o_voted[d], 0);
      chk($sformatf("%s.mism%0d", tag, d), o_mism[d], 0);
      chk($sformatf("%s.uncorr%0d", tag, d), o_unc[d], 0);
      chk($sformatf("%s.fault%0d", tag, d), o_fault[d], 0);
      chk($sformatf("%s.mode%0d", tag, d), o_mode[d], 0);
      chk($sformatf("%s.err%0d", tag, d), o_err[d], 0);
      chk($sformatf("%s.in_ready%0d", tag, d), in_ready[d], 1);
    end
  endtask

  // Drive one beat, hold it until accepted (bounded), queue its expected
  // output, then check status just after the accepting edge.
  task automatic send(vec_t v);
    int tries;
    bit acc;
    tries = 0;
    acc   = 0;
    in_valid[v.d] = 1'b1;
    rep_a[v.d] = v.a; rep_b[v.d] = v.b; rep_c[v.d] = v.c;
    clear[v.d] = v.clr;
    while (!acc && tries < 40) begin
      @(negedge clk);
      if (in_ready[v.d]) begin
        acc = 1;
        if (v.d == 0) q0.push_back(v);
        else          q1.push_back(v);
      end
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid[v.d] = 1'b0;
    clear[v.d]    = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept row%0d: in_ready stayed 0 for %0d cycles, expected accept", v.id, tries);
    end else begin
      chk($sformatf("fault%0d row%0d", v.d, v.id), o_fault[v.d], v.fault);
      chk($sformatf("mode%0d row%0d", v.d, v.id), o_mode[v.d], v.mode);
      chk($sformatf("err%0d row%0d", v.d, v.id), o_err[v.d], v.err);
    end
  endtask

  // Scoreboard: every output handshake pops and compares one expected word.
  always @(negedge clk) begin : mon
    vec_t e;
    bit   got;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (o_valid[d] && out_ready[d]) begin
          got = 0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
          if (!got) begin
            tests++;
            fails++;
            $display("FAIL out%0d unexpected word: voted=0x%0h, none expected", d, o_voted[d]);
          end else begin
            chk($sformatf("voted%0d row%0d", d, e.id), o_voted[d], e.voted);
            chk($sformatf("mism%0d row%0d", d, e.id), o_mism[d], e.mism);
            chk($sformatf("uncorr%0d row%0d", d, e.id), o_unc[d], e.unc);
          end
        end
      end
    end
  end

  initial begin
    vec_t bp[$];

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0; clear[d] = 0; out_ready[d] = 1;
      rep_a[d] = '0; rep_b[d] = '0; rep_c[d] = '0;
    end

    // ---- vector table: instance 0 (CARE_MASK=FF, CNT_W=16) ----
    //           d  a      b      c      clr  voted  mism    unc  fault   mode   err
    tbl.push_back(mk(0, 8'h3C, 8'h3C, 8'hFF, 0, 8'h3C, 3'b100, 0, 3'b000, 2'b00, 1));
    tbl.push_back(mk(0, 8'h3C, 8'h3C, 8'hFF, 0, 8'h3C, 3'b100, 0, 3'b000, 2'b00, 2));
    tbl.push_back(mk(0, 8'h3C, 8'h3C, 8'h3C, 0, 8'h3C, 3'b000, 0, 3'b000, 2'b00, 2));
    tbl.push_back(mk(0, 8'h81, 8'h81, 8'h80, 0, 8'h81, 3'b100, 0, 3'b000, 2'b00, 3));
    tbl.push_back(mk(0, 8'h81, 8'h81, 8'h00, 0, 8'h81, 3'b100, 0, 3'b000, 2'b00, 4));
    tbl.push_back(mk(0, 8'h81, 8'h81, 8'h01, 0, 8'h81, 3'b100, 0, 3'b100, 2'b01, 5));
    tbl.push_back(mk(0, 8'h5A, 8'h5A, 8'h00, 0, 8'h5A, 3'b000, 0, 3'b100, 2'b01, 5));
    tbl.push_back(mk(0, 8'h5A, 8'h5B, 8'h5A, 0, 8'h5A, 3'b000, 1, 3'b100, 2'b01, 6));
    tbl.push_back(mk(0, 8'h01, 8'h02, 8'h00, 1, 8'h01, 3'b000, 1, 3'b000, 2'b00, 0));
    tbl.push_back(mk(0, 8'h03, 8'h05, 8'h06, 0, 8'h07, 3'b111, 0, 3'b000, 2'b00, 1));
    tbl.push_back(mk(0, 8'h03, 8'h05, 8'h06, 0, 8'h07, 3'b111, 0, 3'b000, 2'b00, 2));
    tbl.push_back(mk(0, 8'h03, 8'h05, 8'h06, 0, 8'h07, 3'b111, 0, 3'b110, 2'b10, 3));
    tbl.push_back(mk(0, 8'hAB, 8'hCD, 8'hEF, 0, 8'hAB, 3'b000, 0, 3'b110, 2'b10, 3));
    tbl.push_back(mk(0, 8'h11, 8'h11, 8'h11, 1, 8'h11, 3'b000, 0, 3'b000, 2'b00, 0));
    // ---- instance 1 (CARE_MASK=FE, CNT_W=2) ----
    tbl.push_back(mk(1, 8'h10, 8'h10, 8'h20, 0, 8'h10, 3'b100, 0, 3'b000, 2'b00, 1));
    tbl.push_back(mk(1, 8'h10, 8'h10, 8'h20, 0, 8'h10, 3'b100, 0, 3'b000, 2'b00, 2));
    tbl.push_back(mk(1, 8'h10, 8'h10, 8'h20, 0, 8'h10, 3'b100, 0, 3'b100, 2'b01, 3));
    tbl.push_back(mk(1, 8'h10, 8'h11, 8'h00, 0, 8'h10, 3'b000, 0, 3'b100, 2'b01, 3));
    tbl.push_back(mk(1, 8'h10, 8'h12, 8'h00, 0, 8'h10, 3'b000, 1, 3'b100, 2'b01, 3));
    tbl.push_back(mk(1, 8'h10, 8'h12, 8'h00, 1, 8'h10, 3'b000, 1, 3'b000, 2'b00, 0));
    tbl.push_back(mk(1, 8'h10, 8'h10, 8'h11, 0, 8'h10, 3'b000, 0, 3'b000, 2'b00, 0));
    tbl.push_back(mk(1, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 3'b001, 0, 3'b000, 2'b00, 1));
    tbl.push_back(mk(1, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 3'b010, 0, 3'b000, 2'b00, 2));
    tbl.push_back(mk(1, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 3'b100, 0, 3'b000, 2'b00, 3));
    tbl.push_back(mk(1, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 3'b001, 0, 3'b000, 2'b00, 3));
    tbl.push_back(mk(1, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 3'b010, 0, 3'b000, 2'b00, 3));
    for (int i = 0; i < tbl.size(); i++) tbl[i].id = i;

    // ---- backpressure beats for instance 0 ----
    bp.push_back(mk(0, 8'h40, 8'h40, 8'h41, 0, 8'h40, 3'b100, 0, 3'b000, 2'b00, 1));
    bp.push_back(mk(0, 8'h42, 8'h43, 8'h43, 0, 8'h43, 3'b001, 0, 3'b000, 2'b00, 2));
    bp.push_back(mk(0, 8'h44, 8'h44, 8'h44, 0, 8'h44, 3'b000, 0, 3'b000, 2'b00, 2));
    bp.push_back(mk(0, 8'h45, 8'h46, 8'h45, 0, 8'h45, 3'b010, 0, 3'b000, 2'b00, 3));
    for (int i = 0; i < bp.size(); i++) bp[i].id = 100 + i;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("reset");

    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);

    repeat (2) @(posedge clk);
    #1;

    // ---- stall: hold out_ready low while more beats are offered ----
    out_ready[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < bp.size(); i++) send(bp[i]);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!o_valid[0] && n < 10) begin
          @(negedge clk);
          n++;
        end
        repeat (4) begin
          chk("stall.out_valid", o_valid[0], 1);
          chk("stall.in_ready", in_ready[0], 0);
          chk("stall.voted", o_voted[0], 8'h40);
          chk("stall.err", o_err[0], 1);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join

    repeat (2) @(posedge clk);
    #1;

    // ---- async reset while a word is held ----
    out_ready[0] = 1'b0;
    send(mk(0, 8'h77, 8'h77, 8'h77, 0, 8'h77, 3'b000, 0, 3'b000, 2'b00, 3));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    send(mk(0, 8'h99, 8'h99, 8'h99, 0, 8'h99, 3'b000, 0, 3'b000, 2'b00, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("drain.q0", q0.size(), 0);
    chk("drain.q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
